cnt_updn_mod: RTL



---
 rtl/cnt_updn_mod_if.sv | 33 +++
 rtl/cnt_updn_mod.sv | 110 +++++++++++
 2 files changed

// File: rtl/cnt_updn_mod_if.sv
`default_nettype none
// ============================================================================
// Module      : cnt_updn_mod_if
// Description : Control and status bundle for the up/down modulo counter.
//               The master side drives enable, load, direction, limit mode
//               and load value; the slave side (the counter) returns the
//               count, terminal-count flag and event pulses.
// Revision    : 1.0 - initial release
// ============================================================================
interface cnt_updn_mod_if #(
   parameter int N = 4
);
   logic         en;
   logic         ld;
   logic         up;
   logic         sat;
   logic [N-1:0] D;
   logic [N-1:0] q;
   logic         tc;
   logic         wrap;
   logic         ld_err;

   modport master (
      output en, ld, up, sat, D,
      input  q, tc, wrap, ld_err
   );

   modport slave (
      input  en, ld, up, sat, D,
      output q, tc, wrap, ld_err
   );
endinterface
`default_nettype wire

// File: rtl/cnt_updn_mod.sv
`default_nettype none
// ============================================================================
// Module      : cnt_updn_mod
// Description : Parametrised up/down modulo counter over 0..MOD-1 with
//               synchronous load (out-of-range loads clamp to MOD-1),
//               wrap or saturate at the limits, combinational terminal
//               count and registered one-cycle wrap / load-error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module cnt_updn_mod #(
   parameter int              N   = 4,
   parameter longint unsigned MOD = 64'd1 << N
) (
   input  wire              Clk,
   input  wire              reset,
   cnt_updn_mod_if.slave    bus
);

   // Elaboration-time legality checks on the configuration.
   if (N < 1 || N > 32) begin : g_bad_width
      $error("cnt_updn_mod: N=%0d outside 1..32", N);
   end
   if (MOD < 64'd2 || MOD > (64'd1 << N)) begin : g_bad_mod
      $error("cnt_updn_mod: MOD=%0d outside 2..2**N", MOD);
   end

   // Upper limit held in N+1 bits so that MOD=2**N still compares cleanly.
   localparam longint unsigned LIM_FULL = MOD - 64'd1;
   localparam logic [N:0]      MOD_MAX  = LIM_FULL[N:0];

   logic [N-1:0] q_r;
   logic         wrap_r;
   logic         ld_err_r;

   logic [N-1:0] q_nxt;
   logic         wrap_nxt;
   logic         ld_err_nxt;

   logic [N:0]   q_ext;
   logic [N:0]   d_ext;
   logic         at_max;
   logic         at_zero;
   logic         d_over;

   assign q_ext   = {1'b0, q_r};
   assign d_ext   = {1'b0, bus.D};
   assign at_max  = (q_ext == MOD_MAX);
   assign at_zero = (q_ext == '0);
   assign d_over  = (d_ext > MOD_MAX);

   // Next-state selection: load beats counting, limits are tested before
   // stepping so the count never leaves 0..MOD-1.
   always_comb begin
      q_nxt      = q_r;
      wrap_nxt   = 1'b0;
      ld_err_nxt = 1'b0;
      if (bus.en) begin
         if (bus.ld) begin
            if (d_over) begin
               q_nxt      = MOD_MAX[N-1:0];
               ld_err_nxt = 1'b1;
            end else begin
               q_nxt = bus.D;
            end
         end else if (bus.up) begin
            if (at_max) begin
               if (!bus.sat) begin
                  q_nxt    = '0;
                  wrap_nxt = 1'b1;
               end
            end else begin
               q_nxt = q_r + N'(1);
            end
         end else begin
            if (at_zero) begin
               if (!bus.sat) begin
                  q_nxt    = MOD_MAX[N-1:0];
                  wrap_nxt = 1'b1;
               end
            end else begin
               q_nxt = q_r - N'(1);
            end
         end
      end
   end

   // Count and pulse registers; reset clears everything and suppresses pulses.
   always_ff @(posedge Clk) begin
      if (reset) begin
         q_r      <= '0;
         wrap_r   <= 1'b0;
         ld_err_r <= 1'b0;
      end else begin
         q_r      <= q_nxt;
         wrap_r   <= wrap_nxt;
         ld_err_r <= ld_err_nxt;
      end
   end

   // Terminal count follows the current direction with no register delay.
   always_comb begin
      bus.tc = bus.up ? at_max : at_zero;
   end

   assign bus.q      = q_r;
   assign bus.wrap   = wrap_r;
   assign bus.ld_err = ld_err_r;

endmodule
`default_nettype wire
